// File: rtl/inbuf_dout_word_serializer_pkg.sv
// inbuf_dout_word_serializer_pkg: beat/word geometry shared by the input-buffer side and the serializer.
package inbuf_dout_word_serializer_pkg;
  localparam int MAX_CHANNEL_NUM = 128;
  localparam int PIX_W = 9;
  localparam int WORD_W = 32;
  localparam int BEAT_W = MAX_CHANNEL_NUM * PIX_W;
  localparam int WORDS = (BEAT_W + WORD_W - 1) / WORD_W;
  localparam int IDX_W = $clog2(WORDS);
endpackage

// File: rtl/inbuf_dout_word_serializer_if.sv
// inbuf_dout_word_serializer_if: beat input and word output handshakes of the serializer.
interface inbuf_dout_word_serializer_if;
  import inbuf_dout_word_serializer_pkg::*;
  logic flush;
  logic [BEAT_W-1:0] inbuf_dout;
  logic inbuf_dout_vld;
  logic inbuf_dout_rdy;
  logic [WORD_W-1:0] word;
  logic word_vld;
  logic word_rdy;
  logic [IDX_W-1:0] word_idx;
  logic word_last;
  logic [1:0] occupancy;
  modport slave (
    input flush, inbuf_dout, inbuf_dout_vld, word_rdy,
    output inbuf_dout_rdy, word, word_vld, word_idx, word_last, occupancy
  );
  modport master (
    output flush, inbuf_dout, inbuf_dout_vld, word_rdy,
    input inbuf_dout_rdy, word, word_vld, word_idx, word_last, occupancy
  );
endinterface

// File: rtl/inbuf_dout_word_serializer.sv
// inbuf_dout_word_serializer: double-buffered beat store drained as WORD_W-bit words, word 0 first.
module inbuf_dout_word_serializer
  import inbuf_dout_word_serializer_pkg::*;
(
  input logic clk_i,
  input logic rst_i,
  inbuf_dout_word_serializer_if.slave bus
);
  logic [BEAT_W-1:0] slot [2];
  logic [WORDS*WORD_W-1:0] cur;
  logic wr_ptr, rd_ptr, acc, hs, last, vld;
  logic [1:0] cnt;
  logic [IDX_W-1:0] idx;
  assign vld = cnt != 2'd0;
  assign last = idx == IDX_W'(WORDS - 1);
  assign bus.inbuf_dout_rdy = cnt != 2'd2 && !rst_i && !bus.flush;
  assign acc = bus.inbuf_dout_vld && bus.inbuf_dout_rdy;
  assign hs = vld && bus.word_rdy && !bus.flush;
  // zero-extend so a partial top word reads its unused bits as 0
  assign cur = (WORDS*WORD_W)'(slot[rd_ptr]);
  assign bus.word = vld ? cur[idx*WORD_W +: WORD_W] : '0;
  assign bus.word_vld = vld;
  assign bus.word_idx = idx;
  assign bus.word_last = vld && last;
  assign bus.occupancy = cnt;
  always_ff @(posedge clk_i)
    if (acc) slot[wr_ptr] <= bus.inbuf_dout;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      idx <= '0;
    end else if (bus.flush) begin
      cnt <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      idx <= '0;
    end else begin
      if (acc) wr_ptr <= ~wr_ptr;
      if (hs) idx <= last ? '0 : idx + 1'b1;
      if (hs && last) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(acc) - 2'(hs && last);
    end
endmodule

// File: tb/tb_inbuf_dout_word_serializer.sv
// tb_inbuf_dout_word_serializer: directed steps with a beat-queue scoreboard checked every cycle.
module tb_inbuf_dout_word_serializer;
  import inbuf_dout_word_serializer_pkg::*;
  typedef logic [BEAT_W-1:0] beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  inbuf_dout_word_serializer_if bus();
  inbuf_dout_word_serializer dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  int checks = 0;
  int errs = 0;
  beat_t q[$];
  int ei = 0;
  task automatic chk(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic beat_t mk(input logic [WORD_W-1:0] base);
    beat_t b;
    for (int k = 0; k < WORDS; k++) b[k*WORD_W +: WORD_W] = base | WORD_W'(k);
    return b;
  endfunction
  function automatic beat_t rnd();
    beat_t b;
    for (int k = 0; k < WORDS; k++) b[k*WORD_W +: WORD_W] = $urandom;
    return b;
  endfunction
  task automatic expect_out(input string tag, input logic [WORD_W-1:0] w, input int ix, input logic l, input logic v, input int oc);
    chk({tag, "_word"}, bus.word, w);
    chk({tag, "_idx"}, WORD_W'(bus.word_idx), WORD_W'(ix));
    chk({tag, "_last"}, WORD_W'(bus.word_last), WORD_W'(l));
    chk({tag, "_vld"}, WORD_W'(bus.word_vld), WORD_W'(v));
    chk({tag, "_occ"}, WORD_W'(bus.occupancy), WORD_W'(oc));
  endtask
  // one clock: drive at negedge, check against the scoreboard, step it at the posedge
  task automatic cyc(input logic v, input beat_t b, input logic wr, input logic fl, output logic acc);
    beat_t h;
    logic ev, hs;
    bus.inbuf_dout_vld = v;
    bus.inbuf_dout = b;
    bus.word_rdy = wr;
    bus.flush = fl;
    #1;
    ev = q.size() != 0;
    h = ev ? q[0] : '0;
    chk("sb_rdy", WORD_W'(bus.inbuf_dout_rdy), WORD_W'(q.size() < 2 && !fl));
    chk("sb_vld", WORD_W'(bus.word_vld), WORD_W'(ev));
    chk("sb_word", bus.word, ev ? h[ei*WORD_W +: WORD_W] : '0);
    chk("sb_idx", WORD_W'(bus.word_idx), WORD_W'(ei));
    chk("sb_last", WORD_W'(bus.word_last), WORD_W'(ev && ei == WORDS - 1));
    chk("sb_occ", WORD_W'(bus.occupancy), WORD_W'(q.size()));
    acc = v && q.size() < 2 && !fl;
    hs = ev && wr && !fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
      ei = 0;
    end else begin
      if (hs) begin
        if (ei == WORDS - 1) begin
          void'(q.pop_front());
          ei = 0;
        end else ei++;
      end
      if (acc) q.push_back(b);
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n, input logic wr);
    logic a;
    for (int i = 0; i < n; i++) cyc(1'b0, '0, wr, 1'b0, a);
  endtask
  initial begin
    beat_t a_b, b_b, c_b, rb[20];
    logic a;
    int n, got;
    bus.flush = 1'b0;
    bus.inbuf_dout = '0;
    bus.inbuf_dout_vld = 1'b0;
    bus.word_rdy = 1'b1;
    @(negedge clk);
    expect_out("reset", '0, 0, 1'b0, 1'b0, 0);
    chk("reset_rdy", WORD_W'(bus.inbuf_dout_rdy), '0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_rdy", WORD_W'(bus.inbuf_dout_rdy), 1);
    // 1: single beat drains in order with last only on word 35
    a_b = mk(32'hA500_0000);
    cyc(1'b1, a_b, 1'b1, 1'b0, a);
    chk("t1_accept", WORD_W'(a), 1);
    for (int k = 0; k < WORDS; k++) begin
      expect_out("t1", 32'hA500_0000 | WORD_W'(k), k, k == WORDS - 1, 1'b1, 1);
      cyc(1'b0, '0, 1'b1, 1'b0, a);
    end
    expect_out("t1_done", '0, 0, 1'b0, 1'b0, 0);
    // 2: two beats back-to-back, no bubble
    a_b = mk(32'h1100_0000);
    b_b = mk(32'h2200_0000);
    cyc(1'b1, a_b, 1'b1, 1'b0, a);
    cyc(1'b1, b_b, 1'b1, 1'b0, a);
    chk("t2_full_rdy", WORD_W'(bus.inbuf_dout_rdy), '0);
    expect_out("t2_start", 32'h1100_0001, 1, 1'b0, 1'b1, 2);
    idle(2 * WORDS - 1, 1'b1);
    expect_out("t2_done", '0, 0, 1'b0, 1'b0, 0);
    // 3: consumer stalled, third beat held off
    a_b = mk(32'h3100_0000);
    b_b = mk(32'h3200_0000);
    c_b = mk(32'h3300_0000);
    cyc(1'b1, a_b, 1'b0, 1'b0, a);
    cyc(1'b1, b_b, 1'b0, 1'b0, a);
    cyc(1'b1, c_b, 1'b0, 1'b0, a);
    chk("t3_third_refused", WORD_W'(a), '0);
    cyc(1'b1, c_b, 1'b0, 1'b0, a);
    chk("t3_rdy", WORD_W'(bus.inbuf_dout_rdy), '0);
    expect_out("t3_frozen", 32'h3100_0000, 0, 1'b0, 1'b1, 2);
    got = 0;
    for (int i = 0; i < 4 * WORDS; i++) begin
      cyc(got == 0, c_b, 1'b1, 1'b0, a);
      if (a) got = 1;
    end
    chk("t3_third_taken", WORD_W'(got), 1);
    expect_out("t3_done", '0, 0, 1'b0, 1'b0, 0);
    // 4: random beats with random consumer backpressure
    for (int i = 0; i < 20; i++) rb[i] = rnd();
    n = 0;
    for (int c = 0; c < 3000 && (n < 20 || q.size() != 0); c++) begin
      cyc(n < 20 && $urandom_range(0, 1) == 1, n < 20 ? rb[n] : '0, $urandom_range(0, 1) == 1, 1'b0, a);
      if (a) n++;
    end
    chk("t4_all_sent", WORD_W'(n), 20);
    chk("t4_drained", WORD_W'(q.size()), 0);
    // 5: last-word handshake coincides with a new accept at cnt=1
    a_b = mk(32'h5100_0000);
    b_b = mk(32'h5200_0000);
    cyc(1'b1, a_b, 1'b1, 1'b0, a);
    idle(WORDS - 1, 1'b1);
    expect_out("t5_last", 32'h5100_0023, WORDS - 1, 1'b1, 1'b1, 1);
    cyc(1'b1, b_b, 1'b1, 1'b0, a);
    chk("t5_accept", WORD_W'(a), 1);
    expect_out("t5_next", 32'h5200_0000, 0, 1'b0, 1'b1, 1);
    idle(WORDS, 1'b1);
    // 6: flush with two beats held at idx 17, then reset mid-beat
    a_b = mk(32'h6100_0000);
    b_b = mk(32'h6200_0000);
    c_b = mk(32'h6300_0000);
    cyc(1'b1, a_b, 1'b0, 1'b0, a);
    cyc(1'b1, b_b, 1'b0, 1'b0, a);
    idle(17, 1'b1);
    expect_out("t6_pre_flush", 32'h6100_0011, 17, 1'b0, 1'b1, 2);
    cyc(1'b1, c_b, 1'b1, 1'b1, a);
    expect_out("t6_flushed", '0, 0, 1'b0, 1'b0, 0);
    cyc(1'b1, c_b, 1'b1, 1'b0, a);
    expect_out("t6_after_flush", 32'h6300_0000, 0, 1'b0, 1'b1, 1);
    idle(10, 1'b1);
    rst = 1'b1;
    #1;
    expect_out("t6_in_reset", '0, 0, 1'b0, 1'b0, 0);
    chk("t6_reset_rdy", WORD_W'(bus.inbuf_dout_rdy), '0);
    q.delete();
    ei = 0;
    @(negedge clk);
    rst = 1'b0;
    a_b = mk(32'h6400_0000);
    cyc(1'b1, a_b, 1'b1, 1'b0, a);
    expect_out("t6_after_reset", 32'h6400_0000, 0, 1'b0, 1'b1, 1);
    idle(WORDS, 1'b1);
    expect_out("t6_done", '0, 0, 1'b0, 1'b0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
